// File: rtl/id_ex_stage_if.sv
// Fetch <-> decode bus: decoded instruction fields flow down, stall and redirect flow back.
interface id_ex_stage_if;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] target;
  logic [31:0] pc;
  logic        register_write;
  logic        branch_o;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;

  modport master (
    output opcode, rs, rt, rd, shamt, funct, immediate, target, pc, register_write, branch_o,
    input  stall, branch, branch_target
  );

  modport slave (
    input  opcode, rs, rt, rd, shamt, funct, immediate, target, pc, register_write, branch_o,
    output stall, branch, branch_target
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID stage: register file with bypass, branch resolution, hazard stall and the ID/EX latch.
// Define ID_REGFILE_RESET_EN to clear the register file on reset; otherwise it has no reset.
module id_ex_stage #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          NREGS    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave id_bus,
  input  logic         hold,
  input  logic         wb_we,
  input  logic [4:0]   wb_addr,
  input  logic [31:0]  wb_data,
  input  logic         mem_we,
  input  logic [4:0]   mem_addr,
  input  logic [31:0]  mem_data,
  input  logic         mem_is_load,
  output logic [5:0]   ex_op,
  output logic [5:0]   ex_funct,
  output logic [4:0]   ex_shamt,
  output logic [4:0]   ex_rs,
  output logic [4:0]   ex_rt,
  output logic [4:0]   ex_rd,
  output logic [31:0]  ex_rs_val,
  output logic [31:0]  ex_rt_val,
  output logic [31:0]  ex_imm,
  output logic         ex_reg_write,
  output logic         ex_is_load,
  output logic [31:0]  ex_link,
  output logic [31:0]  ex_pc
);

  logic [31:0] regs [1:NREGS-1];
  logic [31:0] rs_val, rt_val, imm_ext;
  logic        cmp_rs, cmp_rt, load_use, br_hazard, hazard, stall_i, taken, is_link;
  logic [4:0]  dest;

`ifdef ID_REGFILE_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end
`else
  // No reset here so the array can map onto RAM; r0 is never stored.
  always_ff @(posedge clk) begin
    if (wb_we && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
  end
`endif

  // An ALU result in MEM beats the write-back value, which beats the stored copy.
  function automatic logic [31:0] read_operand(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    else if (mem_we && mem_addr == idx && !mem_is_load) return mem_data;
    else if (wb_we && wb_addr == idx) return wb_data;
    else return regs[idx];
  endfunction

  always_comb begin
    rs_val = read_operand(id_bus.rs);
    rt_val = read_operand(id_bus.rt);
  end

  always_comb begin
    cmp_rs    = id_bus.branch_o && (id_bus.opcode inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7});
    cmp_rt    = id_bus.branch_o && (id_bus.opcode inside {6'd4, 6'd5});
    load_use  = ex_is_load && ex_rd != 5'd0 && (ex_rd == id_bus.rs || ex_rd == id_bus.rt);
    br_hazard = (ex_reg_write && ex_rd != 5'd0 &&
                 ((cmp_rs && ex_rd == id_bus.rs) || (cmp_rt && ex_rd == id_bus.rt))) ||
                (mem_is_load &&
                 ((cmp_rs && mem_addr == id_bus.rs) || (cmp_rt && mem_addr == id_bus.rt)));
    hazard    = load_use || br_hazard;
    stall_i   = rst_n && (hold || hazard);
  end

  always_comb begin
    taken = 1'b0;
    case (id_bus.opcode)
      6'd1: begin
        if (id_bus.rt == 5'd0 || id_bus.rt == 5'd16)      taken = rs_val[31];
        else if (id_bus.rt == 5'd1 || id_bus.rt == 5'd17) taken = ~rs_val[31];
      end
      6'd2, 6'd3: taken = 1'b1;
      6'd4:       taken = (rs_val == rt_val);
      6'd5:       taken = (rs_val != rt_val);
      6'd6:       taken = rs_val[31] || (rs_val == 32'd0);
      6'd7:       taken = !rs_val[31] && (rs_val != 32'd0);
      default:    taken = 1'b0;
    endcase
  end

  always_comb begin
    id_bus.stall  = stall_i;
    id_bus.branch = rst_n && id_bus.branch_o && !stall_i && taken;
    if (id_bus.opcode == 6'd2 || id_bus.opcode == 6'd3)
      id_bus.branch_target = {id_bus.pc[31:28], id_bus.target, 2'b00};
    else
      id_bus.branch_target = id_bus.pc + {{14{id_bus.immediate[15]}}, id_bus.immediate, 2'b00};
  end

  // Linking branches and jal always write r31.
  always_comb begin
    is_link = (id_bus.opcode == 6'd3) ||
              (id_bus.opcode == 6'd1 && (id_bus.rt == 5'd16 || id_bus.rt == 5'd17));
    dest    = is_link ? 5'd31 : id_bus.rd;
    if (id_bus.opcode inside {6'd12, 6'd13, 6'd14})
      imm_ext = {16'h0000, id_bus.immediate};
    else
      imm_ext = {{16{id_bus.immediate[15]}}, id_bus.immediate};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_op        <= '0;
      ex_funct     <= '0;
      ex_shamt     <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_link      <= '0;
      ex_pc        <= RESET_PC;
    end else if (!hold) begin
      if (hazard) begin
        ex_op        <= '0;
        ex_funct     <= '0;
        ex_shamt     <= '0;
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_rd        <= '0;
        ex_rs_val    <= '0;
        ex_rt_val    <= '0;
        ex_imm       <= '0;
        ex_reg_write <= 1'b0;
        ex_is_load   <= 1'b0;
        ex_link      <= '0;
        ex_pc        <= '0;
      end else begin
        ex_op        <= id_bus.opcode;
        ex_funct     <= id_bus.funct;
        ex_shamt     <= id_bus.shamt;
        ex_rs        <= id_bus.rs;
        ex_rt        <= id_bus.rt;
        ex_rd        <= dest;
        ex_rs_val    <= rs_val;
        ex_rt_val    <= rt_val;
        ex_imm       <= imm_ext;
        ex_reg_write <= id_bus.register_write;
        ex_is_load   <= (id_bus.opcode >= 6'd32) && (id_bus.opcode <= 6'd38);
        ex_link      <= id_bus.pc + 32'd4;
        ex_pc        <= id_bus.pc;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;
  localparam logic [31:0] RESET_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, wb_we, mem_we, mem_is_load;
  logic [4:0]  wb_addr, mem_addr;
  logic [31:0] wb_data, mem_data;
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_link, ex_pc;
  logic        ex_reg_write, ex_is_load;

  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage #(.RESET_PC(RESET_PC), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_bus(bus), .hold(hold),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_is_load(mem_is_load),
    .ex_op(ex_op), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_link(ex_link), .ex_pc(ex_pc)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic        reg_write;
    logic        is_load;
    logic [31:0] link;
    logic [31:0] pc;
  } ex_t;

  ex_t         m_ex;
  logic [31:0] m_regs [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic ex_t dut_ex();
    return '{op: ex_op, funct: ex_funct, shamt: ex_shamt, rs: ex_rs, rt: ex_rt, rd: ex_rd,
             rs_val: ex_rs_val, rt_val: ex_rt_val, imm: ex_imm, reg_write: ex_reg_write,
             is_load: ex_is_load, link: ex_link, pc: ex_pc};
  endfunction

  // Reference model: the stage's rules written as plain arithmetic over the current inputs.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (mem_we && mem_addr == idx && !mem_is_load) return mem_data;
    if (wb_we && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_hazard();
    bit h;
    int srcs[$];
    h = m_ex.is_load && m_ex.rd != 0 && (m_ex.rd == bus.rs || m_ex.rd == bus.rt);
    if (bus.branch_o) begin
      if (bus.opcode inside {1, 4, 5, 6, 7}) srcs.push_back(int'(bus.rs));
      if (bus.opcode inside {4, 5}) srcs.push_back(int'(bus.rt));
      foreach (srcs[i])
        if ((m_ex.reg_write && m_ex.rd != 0 && int'(m_ex.rd) == srcs[i]) ||
            (mem_is_load && int'(mem_addr) == srcs[i])) h = 1;
    end
    return h;
  endfunction

  function automatic bit m_stall();
    return hold || m_hazard();
  endfunction

  function automatic bit m_branch();
    int a, b;
    bit t;
    a = $signed(m_read(bus.rs));
    b = $signed(m_read(bus.rt));
    case (bus.opcode)
      1: t = (bus.rt == 0 || bus.rt == 16) ? (a < 0) : (bus.rt == 1 || bus.rt == 17) ? (a >= 0) : 0;
      2, 3: t = 1;
      4: t = (a == b);
      5: t = (a != b);
      6: t = (a <= 0);
      7: t = (a > 0);
      default: t = 0;
    endcase
    return bus.branch_o && !m_stall() && t;
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    if (bus.opcode == 2 || bus.opcode == 3) return {bus.pc[31:28], bus.target, 2'b00};
    off = $signed(bus.immediate);
    return bus.pc + 32'(off * 4);
  endfunction

  task automatic m_reset();
    m_ex    = '0;
    m_ex.pc = RESET_PC;
`ifdef ID_REGFILE_RESET_EN
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
`endif
  endtask

  task automatic m_clock();
    ex_t n;
    bit  link;
    if (!hold) begin
      if (m_hazard()) n = '0;
      else begin
        link        = (bus.opcode == 3) || (bus.opcode == 1 && (bus.rt == 16 || bus.rt == 17));
        n.op        = bus.opcode;
        n.funct     = bus.funct;
        n.shamt     = bus.shamt;
        n.rs        = bus.rs;
        n.rt        = bus.rt;
        n.rd        = link ? 5'd31 : bus.rd;
        n.rs_val    = m_read(bus.rs);
        n.rt_val    = m_read(bus.rt);
        n.imm       = (bus.opcode inside {12, 13, 14}) ? {16'h0, bus.immediate}
                                                       : 32'($signed(bus.immediate));
        n.reg_write = bus.register_write;
        n.is_load   = (bus.opcode >= 32 && bus.opcode <= 38);
        n.link      = bus.pc + 32'd4;
        n.pc        = bus.pc;
      end
      m_ex = n;
    end
    if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  // Inputs change on the falling edge; the model steps with the rising edge.
  task automatic tick();
    m_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic rw,
                        input logic [31:0] pc);
    bus.opcode         = op;
    bus.rs             = rs;
    bus.rt             = rt;
    bus.rd             = rd;
    bus.immediate      = imm;
    bus.register_write = rw;
    bus.pc             = pc;
    bus.funct          = 6'($urandom);
    bus.shamt          = 5'($urandom);
    bus.target         = 26'($urandom);
    bus.branch_o       = (op >= 1 && op <= 7);
  endtask

  task automatic idle_side();
    hold        = 0;
    wb_we       = 0; wb_addr  = 0; wb_data  = 0;
    mem_we      = 0; mem_addr = 0; mem_data = 0;
    mem_is_load = 0;
  endtask

  task automatic init_regs();
    idle_side();
    set_id(6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h80000000);
    for (int i = 1; i < 32; i++) begin
      wb_we = 1; wb_addr = 5'(i); wb_data = $urandom;
      tick();
    end
    idle_side();
  endtask

  task automatic test_bypass();
    ex_t got;
    idle_side();
    set_id(6'd0, 5'd5, 5'd6, 5'd7, 16'h0, 1'b1, 32'h80000100);
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    tick();
    n_cmp++;
    if (ex_rs_val !== 32'hDEADBEEF) begin
      n_bad++; $display("[TB] FAIL bypass_wb: ex_rs_val=%h required %h", ex_rs_val, 32'hDEADBEEF);
    end
    mem_we = 1; mem_addr = 5; mem_data = 32'd7; wb_data = 32'h0BAD_F00D;
    tick();
    n_cmp++;
    if (ex_rs_val !== 32'd7) begin
      n_bad++; $display("[TB] FAIL bypass_mem_wins: ex_rs_val=%h required %h", ex_rs_val, 32'd7);
    end
    mem_is_load = 1;
    tick();
    n_cmp++;
    if (ex_rs_val !== 32'h0BAD_F00D) begin
      n_bad++; $display("[TB] FAIL bypass_load_skipped: ex_rs_val=%h required %h", ex_rs_val, 32'h0BADF00D);
    end
    got = dut_ex();
    n_cmp++;
    if (got !== m_ex) begin
      n_bad++; $display("[TB] FAIL bypass_bundle: got %h required %h", got, m_ex);
    end
    idle_side();
  endtask

  task automatic test_load_use();
    idle_side();
    set_id(6'd35, 5'd1, 5'd0, 5'd8, 16'h0010, 1'b1, 32'h80000200);
    tick();
    n_cmp++;
    if (ex_is_load !== 1'b1 || ex_rd !== 5'd8) begin
      n_bad++; $display("[TB] FAIL lw_latched: is_load=%b rd=%0d required 1/8", ex_is_load, ex_rd);
    end
    set_id(6'd0, 5'd8, 5'd2, 5'd9, 16'h0, 1'b1, 32'h80000204);
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL load_use_stall: stall=%b required 1", bus.stall);
    end
    tick();
    n_cmp++;
    if (ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || ex_op !== 6'd0) begin
      n_bad++; $display("[TB] FAIL load_use_bubble: rw=%b rd=%0d op=%0d required 0/0/0", ex_reg_write, ex_rd, ex_op);
    end
    wb_we = 1; wb_addr = 8; wb_data = 32'h12345678;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL load_use_release: stall=%b required 0", bus.stall);
    end
    tick();
    n_cmp++;
    if (ex_rs_val !== 32'h12345678 || ex_reg_write !== 1'b1 || ex_rd !== 5'd9) begin
      n_bad++; $display("[TB] FAIL load_use_add: rs_val=%h rw=%b rd=%0d required 12345678/1/9", ex_rs_val, ex_reg_write, ex_rd);
    end
    idle_side();
  endtask

  task automatic test_branch();
    idle_side();
    set_id(6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h80000300);
    wb_we = 1; wb_addr = 1; wb_data = 32'd3;
    tick();
    wb_addr = 2;
    tick();
    idle_side();
    set_id(6'd4, 5'd1, 5'd2, 5'd0, 16'hFFFC, 1'b0, 32'h80000010);
    #1;
    n_cmp++;
    if (bus.branch !== 1'b1 || bus.branch_target !== 32'h80000000) begin
      n_bad++; $display("[TB] FAIL beq_taken: branch=%b target=%h required 1/80000000", bus.branch, bus.branch_target);
    end
    bus.opcode = 6'd5;
    #1;
    n_cmp++;
    if (bus.branch !== 1'b0) begin
      n_bad++; $display("[TB] FAIL bne_not_taken: branch=%b required 0", bus.branch);
    end
    set_id(6'd0, 5'd0, 5'd0, 5'd1, 16'h0, 1'b1, 32'h80000014);
    tick();
    set_id(6'd4, 5'd1, 5'd2, 5'd0, 16'hFFFC, 1'b0, 32'h80000010);
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1 || bus.branch !== 1'b0) begin
      n_bad++; $display("[TB] FAIL branch_operand_stall: stall=%b branch=%b required 1/0", bus.stall, bus.branch);
    end
    tick();
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.branch !== 1'b1) begin
      n_bad++; $display("[TB] FAIL branch_after_bubble: stall=%b branch=%b required 0/1", bus.stall, bus.branch);
    end
    tick();
  endtask

  task automatic test_jump();
    idle_side();
    set_id(6'd3, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 32'h80000008);
    bus.target = 26'h0000100;
    #1;
    n_cmp++;
    if (bus.branch !== 1'b1 || bus.branch_target !== 32'h80000400) begin
      n_bad++; $display("[TB] FAIL jal_redirect: branch=%b target=%h required 1/80000400", bus.branch, bus.branch_target);
    end
    tick();
    n_cmp++;
    if (ex_rd !== 5'd31 || ex_link !== 32'h8000000C || ex_pc !== 32'h80000008) begin
      n_bad++; $display("[TB] FAIL jal_latch: rd=%0d link=%h pc=%h required 31/8000000c/80000008", ex_rd, ex_link, ex_pc);
    end
  endtask

  task automatic test_hold();
    ex_t         frozen, got;
    logic [31:0] wv [3];
    idle_side();
    set_id(6'd8, 5'd3, 5'd4, 5'd0, 16'h8001, 1'b1, 32'h80000500);
    tick();
    frozen = m_ex;
    for (int k = 0; k < 3; k++) begin
      hold = 1;
      set_id(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), $urandom);
      wb_we = 1; wb_addr = 5'(10 + k); wb_data = $urandom; wv[k] = wb_data;
      #1;
      n_cmp++;
      if (bus.stall !== 1'b1) begin
        n_bad++; $display("[TB] FAIL hold_stall: stall=%b required 1", bus.stall);
      end
      tick();
      got = dut_ex();
      n_cmp++;
      if (got !== frozen) begin
        n_bad++; $display("[TB] FAIL hold_frozen: got %h required %h", got, frozen);
      end
    end
    idle_side();
    set_id(6'd0, 5'd10, 5'd12, 5'd0, 16'h0, 1'b0, 32'h80000600);
    tick();
    n_cmp++;
    if (ex_rs_val !== wv[0] || ex_rt_val !== wv[2]) begin
      n_bad++; $display("[TB] FAIL hold_writes_land: rs_val=%h rt_val=%h required %h/%h", ex_rs_val, ex_rt_val, wv[0], wv[2]);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [16] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                             6'd8, 6'd12, 6'd13, 6'd14, 6'd32, 6'd35, 6'd38, 6'd43};
    logic [4:0] rt1 [5]  = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd5};
    logic [5:0] op;
    logic [4:0] rt;
    bit         es, eb;
    ex_t        got;
    for (int c = 0; c < 400; c++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      rt = (op == 6'd1) ? rt1[$urandom_range(0, 4)] : 5'($urandom_range(0, 7));
      set_id(op, 5'($urandom_range(0, 7)), rt, 5'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom), $urandom);
      hold        = ($urandom_range(0, 7) == 0);
      wb_we       = 1'($urandom); wb_addr  = 5'($urandom_range(0, 7)); wb_data  = $urandom;
      mem_we      = 1'($urandom); mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      mem_is_load = ($urandom_range(0, 3) == 0);
      #1;
      es = m_stall();
      eb = m_branch();
      n_cmp++;
      if (bus.stall !== es || bus.branch !== eb) begin
        n_bad++; $display("[TB] FAIL rand_comb cycle %0d: stall=%b branch=%b required %b/%b", c, bus.stall, bus.branch, es, eb);
      end
      if (eb) begin
        n_cmp++;
        if (bus.branch_target !== m_target()) begin
          n_bad++; $display("[TB] FAIL rand_target cycle %0d: target=%h required %h", c, bus.branch_target, m_target());
        end
      end
      tick();
      got = dut_ex();
      n_cmp++;
      if (got !== m_ex) begin
        n_bad++; $display("[TB] FAIL rand_ex cycle %0d: got %h required %h", c, got, m_ex);
      end
    end
    idle_side();
  endtask

  task automatic test_reset();
    ex_t got;
    idle_side();
    set_id(6'd4, 5'd0, 5'd0, 5'd0, 16'h0040, 1'b0, 32'h80000700);
    #1;
    n_cmp++;
    if (bus.branch !== 1'b1) begin
      n_bad++; $display("[TB] FAIL pre_reset_branch: branch=%b required 1", bus.branch);
    end
    hold = 1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL pre_reset_stall: stall=%b required 1", bus.stall);
    end
    rst_n = 0;
    m_reset();
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.branch !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_drop: stall=%b branch=%b required 0/0", bus.stall, bus.branch);
    end
    got = dut_ex();
    n_cmp++;
    if (got !== m_ex || ex_pc !== RESET_PC) begin
      n_bad++; $display("[TB] FAIL reset_ex: got %h required %h", got, m_ex);
    end
    @(negedge clk);
    rst_n = 1;
    idle_side();
    set_id(6'd0, 5'd5, 5'd0, 5'd0, 16'h0, 1'b0, 32'h80000000);
    tick();
`ifdef ID_REGFILE_RESET_EN
    n_cmp++;
    if (ex_rs_val !== 32'd0) begin
      n_bad++; $display("[TB] FAIL reset_regfile_r5: ex_rs_val=%h required 0", ex_rs_val);
    end
`endif
    got = dut_ex();
    n_cmp++;
    if (got !== m_ex) begin
      n_bad++; $display("[TB] FAIL post_reset_ex: got %h required %h", got, m_ex);
    end
  endtask

  initial begin
    rst_n = 0;
    idle_side();
    set_id(6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h80000000);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    init_regs();
    test_bypass();
    test_load_use();
    test_branch();
    test_jump();
    test_hold();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage directly downstream of the IF/ID fetch-decode unit.
- Consumes decoded fields; holds the 32x32 register file with write-back bypass; resolves branches in ID and returns branch/branch_target/stall to fetch.
- Detects load-use and branch-operand hazards.
- Registers the ID/EX pipeline latch feeding the ALU stage.

Parameters:
- RESET_PC, 32'h80000000, value loaded into ex_pc on reset.
- NREGS, 32, register count; r0 hardwired to 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode/rs/rt/rd/shamt/funct  in  6/5/5/5/5/6  decoded fields from fetch
- immediate  in  16  instruction[15:0]
- target  in  26  jump index
- pc  in  32  ID instruction address + 4
- register_write  in  1  ID instruction writes rd
- branch_o  in  1  opcode is 1..7
- hold  in  1  downstream freeze; no state update
- wb_we/wb_addr/wb_data  in  1/5/32  write-back port
- mem_we/mem_addr/mem_data/mem_is_load  in  1/5/32/1  MEM-stage result for bypass
- stall  out  1  to fetch: hold IR/PC
- branch  out  1  to fetch: redirect
- branch_target  out  32  redirect address
- ex_op/ex_funct/ex_shamt  out  6/6/5  latched fields
- ex_rs/ex_rt/ex_rd  out  5 each  latched register indices
- ex_rs_val/ex_rt_val  out  32 each  latched operands
- ex_imm  out  32  extended immediate
- ex_reg_write/ex_is_load  out  1 each  EX control
- ex_link  out  32  return address (pc+4)
- ex_pc  out  32  latched pc

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* outputs = 0, except ex_pc = RESET_PC.
  - stall = 0, branch = 0.
  - Register file cleared; see optional feature.
- Regfile write:
  - On posedge when wb_we && wb_addr!=0: reg[wb_addr] <= wb_data.
  - Writes are not gated by hold.
- Operand read, combinational, priority highest first:
  - index 0 -> 0
  - mem_we && mem_addr==idx && !mem_is_load -> mem_data
  - wb_we && wb_addr==idx -> wb_data
  - regfile
- Load-use stall: ex_is_load && ex_rd!=0 && ex_rd matches rs or rt of ID -> stall = 1.
- Branch-operand stall, only when branch_o:
  - ex_reg_write && ex_rd!=0 && ex_rd matches a compared source -> stall.
  - mem_is_load && mem_addr matches a compared source -> stall.
- stall also = 1 whenever hold = 1.
- Branch resolution:
  - Computed only when branch_o && !stall; otherwise branch = 0.
  - op 4 beq: rs==rt
  - op 5 bne: rs!=rt
  - op 6 blez: rs<=0 signed
  - op 7 bgtz: rs>0 signed
  - op 1, rt 0/16: bltz; rt 1/17: bgez
  - op 2/3: always taken
- branch_target:
  - Conditional: pc + {sext(immediate),2'b00}, 32-bit wrap.
  - Jumps: {pc[31:28],target,2'b00}.
- Immediate extension:
  - Zero-extend for opcodes 12, 13, 14.
  - Sign-extend otherwise.
- ex_link = pc + 4 (ID address + 8).
- Pipeline latch on posedge:
  - hold = 1 -> all ex_* retain.
  - stall from hazard -> bubble: ex_reg_write = 0, ex_is_load = 0, ex_op = 0, ex_funct = 0, ex_rd = 0; other fields don't-care but are zeroed.
  - Else latch ID values.
  - ex_is_load = (opcode 32..38).
- Taken branch:
  - Delay-slot instruction is the one fetch discards: fetch zeroes IR.
  - This stage latches the branch itself normally, so jal/bltzal/bgezal write rd=31 via ex_link.
- Simultaneous events:
  - wb write to a register being read the same cycle -> bypass value used.
  - mem and wb to the same index -> mem wins.
- Reset mid-stall: stall and branch drop immediately with rst_n.

Optional Feature:
- Macro ID_REGFILE_RESET_EN.
- Defined: all 31 registers cleared asynchronously on rst_n=0.
- Undefined: regfile has no reset, for RAM inference. Contents are X until written; r0 still reads 0. All pipeline outputs still reset.

Test Plan:
- Reset: rst_n=0 mid-run -> all ex_* = 0, ex_pc = 32'h80000000, stall = 0, branch = 0; with macro, reading r5 after release -> 0.
- Bypass: wb_we=1, wb_addr=5, wb_data=32'hDEAD_BEEF while ID reads rs=5 -> ex_rs_val = 32'hDEADBEEF next cycle; mem_addr=5, mem_data=7 simultaneously -> 7.
- Load-use: lw to r8 in EX, ID add reads r8 -> stall=1 one cycle, bubble latched (ex_reg_write=0), then add latches with r8 from wb bypass.
- Branch: beq r1,r2 with r1=r2=3, pc=32'h80000010, imm=16'hFFFC -> branch=1, branch_target=32'h80000000; bne same -> branch=0.
- Jump: jal, target=26'h0000100, pc=32'h80000008 -> branch_target=32'h80000400, ex_rd=31, ex_link=32'h8000000C.
- Hold: hold=1 for 3 cycles with changing inputs -> ex_* frozen, stall=1, regfile writes still land.
